// File: rtl/wb_issuer_if.sv
// Result/writeback bundle bus between execute, the writeback issuer and the regfile.
// Latency: none, wires only.
// Backpressure: res_ready from the issuer back to execute; wb_hold from the regfile back to the issuer.
// Ports: res_* is the execute-side bundle with valid/ready; wb_* is the registered
//        regfile-side bundle; wb_hold is the consumer stall. Lane N maps to suffix N.
//        modport slave = the issuer; modport master = the producer/consumer side.
interface wb_issuer_if #(
    parameter int PTC_W = 7
);
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data1, res_data2, res_data3, res_data4;
    logic [15:0]      res_segdata1, res_segdata2, res_segdata3, res_segdata4;
    logic [2:0]       res_addr1, res_addr2, res_addr3, res_addr4;
    logic [2:0]       res_segaddr1, res_segaddr2, res_segaddr3, res_segaddr4;
    logic [3:0]       res_regld;
    logic [3:0]       res_segld;
    logic [1:0]       res_opsize;
    logic [PTC_W-1:0] res_ptcid;

    logic             wb_hold;
    logic [63:0]      wb_data1, wb_data2, wb_data3, wb_data4;
    logic [15:0]      wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4;
    logic [2:0]       wb_addr1, wb_addr2, wb_addr3, wb_addr4;
    logic [2:0]       wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4;
    logic [1:0]       wb_opsize;
    logic [3:0]       wb_regld;
    logic [3:0]       wb_segld;
    logic [PTC_W-1:0] wb_inst_ptcid;

    modport slave (
        input  res_valid,
        input  res_data1, res_data2, res_data3, res_data4,
        input  res_segdata1, res_segdata2, res_segdata3, res_segdata4,
        input  res_addr1, res_addr2, res_addr3, res_addr4,
        input  res_segaddr1, res_segaddr2, res_segaddr3, res_segaddr4,
        input  res_regld, res_segld, res_opsize, res_ptcid,
        input  wb_hold,
        output res_ready,
        output wb_data1, wb_data2, wb_data3, wb_data4,
        output wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4,
        output wb_addr1, wb_addr2, wb_addr3, wb_addr4,
        output wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4,
        output wb_opsize, wb_regld, wb_segld, wb_inst_ptcid
    );

    modport master (
        output res_valid,
        output res_data1, res_data2, res_data3, res_data4,
        output res_segdata1, res_segdata2, res_segdata3, res_segdata4,
        output res_addr1, res_addr2, res_addr3, res_addr4,
        output res_segaddr1, res_segaddr2, res_segaddr3, res_segaddr4,
        output res_regld, res_segld, res_opsize, res_ptcid,
        output wb_hold,
        input  res_ready,
        input  wb_data1, wb_data2, wb_data3, wb_data4,
        input  wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4,
        input  wb_addr1, wb_addr2, wb_addr3, wb_addr4,
        input  wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4,
        input  wb_opsize, wb_regld, wb_segld, wb_inst_ptcid
    );
endinterface

// File: rtl/wb_issuer.sv
// Writeback issuer: buffers retired result bundles and drives one collision-free regfile write bundle per cycle.
// Latency: 2 edges from acceptance to wb_* (1 edge when WB_BYPASS_EN is defined and the FIFO is empty).
// Backpressure: res_ready drops when the DEPTH-entry FIFO is full; wb_hold freezes the output register and stalls pops.
// Ports: clk, clr (synchronous active-high reset), flush (drop buffered bundles),
//        bus (wb_issuer_if.slave: res_* in with valid/ready, wb_* out, wb_hold in),
//        occupancy (entries currently in the FIFO).
// Build option: define WB_BYPASS_EN to let a bundle skip the empty FIFO straight into the output register.

// Generic single-clock FIFO. Flush and clr both empty it; a push in that cycle is dropped.
// Latency: head visible the edge after the first push.
// Backpressure: push_rdy low when full; pop only when pop_rdy and pop_vld.
module wb_issuer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != FULL);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
        end
    end

    // Storage carries no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module wb_issuer #(
    parameter int DEPTH = 4,
    parameter int PTC_W = 7
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   flush,
    wb_issuer_if.slave             bus,
    output logic [$clog2(DEPTH):0] occupancy
);
    // Index 0 is lane 1.
    typedef struct packed {
        logic [3:0][63:0] data;
        logic [3:0][15:0] segdata;
        logic [3:0][2:0]  addr;
        logic [3:0][2:0]  segaddr;
        logic [3:0]       regld;
        logic [3:0]       segld;
        logic [1:0]       opsize;
        logic [PTC_W-1:0] ptcid;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    // A lower lane loses to any higher enabled lane writing the same register.
    function automatic logic [3:0] resolve_en(input logic [3:0] en, input logic [3:0][2:0] addr);
        logic [3:0] r;
        r = en;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (en[i] && en[j] && (addr[i] == addr[j])) r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic bundle_t resolve(input bundle_t b);
        bundle_t r;
        r       = b;
        r.regld = resolve_en(b.regld, b.addr);
        r.segld = resolve_en(b.segld, b.segaddr);
        return r;
    endfunction

    bundle_t in_b;
    bundle_t head_b;
    bundle_t out_q;
    logic    fifo_push_vld;
    logic    fifo_push_rdy;
    logic    fifo_pop_vld;
    logic    bypass;

    always_comb begin
        in_b         = '0;
        in_b.data    = {bus.res_data4, bus.res_data3, bus.res_data2, bus.res_data1};
        in_b.segdata = {bus.res_segdata4, bus.res_segdata3, bus.res_segdata2, bus.res_segdata1};
        in_b.addr    = {bus.res_addr4, bus.res_addr3, bus.res_addr2, bus.res_addr1};
        in_b.segaddr = {bus.res_segaddr4, bus.res_segaddr3, bus.res_segaddr2, bus.res_segaddr1};
        in_b.regld   = bus.res_regld;
        in_b.segld   = bus.res_segld;
        in_b.opsize  = bus.res_opsize;
        in_b.ptcid   = bus.res_ptcid;
    end

`ifdef WB_BYPASS_EN
    // Empty FIFO and a free output register: the bundle goes straight to wb_*.
    assign bypass = bus.res_valid && !fifo_pop_vld && !bus.wb_hold;
`else
    assign bypass = 1'b0;
`endif

    // A bundle taken by the bypass path must not also land in the FIFO.
    assign fifo_push_vld = bus.res_valid && !bypass;

    wb_issuer_fifo #(
        .W     (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .flush    (flush),
        .push_vld (fifo_push_vld),
        .push_dat (in_b),
        .push_rdy (fifo_push_rdy),
        .pop_rdy  (!bus.wb_hold),
        .pop_vld  (fifo_pop_vld),
        .pop_dat  (head_b),
        .count    (occupancy)
    );

    assign bus.res_ready = fifo_push_rdy;

    // Output register. Idle cycles clear only the enables so the regfile sees no
    // write; data/address keep their last values.
    always_ff @(posedge clk) begin
        if (clr) begin
            out_q <= '0;
        end else if (flush) begin
            out_q.regld <= '0;
            out_q.segld <= '0;
        end else if (!bus.wb_hold) begin
            if (fifo_pop_vld) begin
                out_q <= resolve(head_b);
            end else if (bypass) begin
                out_q <= resolve(in_b);
            end else begin
                out_q.regld <= '0;
                out_q.segld <= '0;
            end
        end
    end

    assign bus.wb_data1      = out_q.data[0];
    assign bus.wb_data2      = out_q.data[1];
    assign bus.wb_data3      = out_q.data[2];
    assign bus.wb_data4      = out_q.data[3];
    assign bus.wb_segdata1   = out_q.segdata[0];
    assign bus.wb_segdata2   = out_q.segdata[1];
    assign bus.wb_segdata3   = out_q.segdata[2];
    assign bus.wb_segdata4   = out_q.segdata[3];
    assign bus.wb_addr1      = out_q.addr[0];
    assign bus.wb_addr2      = out_q.addr[1];
    assign bus.wb_addr3      = out_q.addr[2];
    assign bus.wb_addr4      = out_q.addr[3];
    assign bus.wb_segaddr1   = out_q.segaddr[0];
    assign bus.wb_segaddr2   = out_q.segaddr[1];
    assign bus.wb_segaddr3   = out_q.segaddr[2];
    assign bus.wb_segaddr4   = out_q.segaddr[3];
    assign bus.wb_regld      = out_q.regld;
    assign bus.wb_segld      = out_q.segld;
    assign bus.wb_opsize     = out_q.opsize;
    assign bus.wb_inst_ptcid = out_q.ptcid;
endmodule

// File: doc/wb_issuer.md
Name: wb_issuer

Overview:
- Writeback-side producer for the register/segment file write ports consumed by the register-read/address-generation stage.
- Accepts retired result bundles from execute via valid/ready, buffers them in a small FIFO, and drives one registered bundle per cycle: up to 4 GPR writes, 4 segment writes, opsize and the producing instruction's ptcid.
- Resolves same-address lane collisions so the regfile never sees two writes to one register in a cycle.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- PTC_W, 7, ptcid width

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- res_valid  in  1  execute presents a bundle
- res_ready  out  1  issuer can accept (FIFO not full)
- res_data1..res_data4  in  64 each  GPR result per lane
- res_segdata1..res_segdata4  in  16 each  segment result per lane
- res_addr1..res_addr4  in  3 each  GPR dest address per lane
- res_segaddr1..res_segaddr4  in  3 each  segment dest address per lane
- res_regld  in  4  GPR lane enables
- res_segld  in  4  segment lane enables
- res_opsize  in  2  write size
- res_ptcid  in  PTC_W  producer ptcid
- flush  in  1  pipeline flush; drop all buffered bundles
- wb_hold  in  1  consumer cannot take a new bundle this cycle
- wb_data1..wb_data4  out  64 each
- wb_segdata1..wb_segdata4  out  16 each
- wb_addr1..wb_addr4, wb_segaddr1..wb_segaddr4  out  3 each
- wb_opsize  out  2
- wb_regld, wb_segld  out  4 each
- wb_inst_ptcid  out  PTC_W
- occupancy  out  log2(DEPTH)+1  entries in FIFO

Behaviour:
- Reset (clr=1 at posedge): FIFO empty, occupancy=0, res_ready=1, wb_regld=0, wb_segld=0, all other wb_* outputs =0. Reset overrides push, pop and flush in the same cycle.
- Push: res_valid & res_ready at posedge writes one entry. res_ready = (occupancy != DEPTH), combinational from state only.
- Output register:
  - Loaded at posedge when wb_hold=0 and FIFO non-empty: pops the head entry.
  - When wb_hold=0 and FIFO empty: wb_regld/wb_segld clear to 0; data/address fields keep their last values.
  - When wb_hold=1: all wb_* outputs hold and no pop occurs.
  - Latency without bypass: bundle accepted at edge N appears on wb_* after edge N+1 at the earliest.
- Collision resolution, applied at pop before loading:
  - For GPR lanes i<j with both enabled and res_addr_i==res_addr_j, clear lane i's enable; the higher lane wins.
  - Segment lanes use the same rule.
  - Data fields pass unchanged.
- Simultaneous push and pop: allowed at full. res_ready is 0 when full, so no push occurs that cycle; occupancy decrements. Pointers wrap mod DEPTH.
- Flush: at posedge, empties the FIFO (occupancy=0) and clears wb_regld/wb_segld. A push in the flush cycle is discarded. A bundle already on wb_* in the flush cycle remains visible until that edge.
- Empty FIFO with wb_hold=0: output enables are 0 and no spurious writes are issued.
- Sizes and ptcid are forwarded unchanged per entry.

Optional Feature:
- WB_BYPASS_EN defined: when the FIFO is empty, wb_hold=0 and res_valid=1, the incoming bundle (collision-resolved) loads the output register directly at the same edge without occupying a FIFO entry. Latency is 1 cycle from acceptance.
- WB_BYPASS_EN undefined: every bundle passes through the FIFO. Minimum latency is 2 edges.

Test Plan:
- Single bundle: res_regld=0001, res_addr1=3, res_data1=64'hDEAD_BEEF, res_ptcid=7'h15, wb_hold=0 -> wb_regld=0001, wb_addr1=3, wb_data1=DEAD_BEEF, wb_inst_ptcid=15 appear after 2 edges (1 with WB_BYPASS_EN). The next cycle has wb_regld=0.
- Collision: res_regld=1011, res_addr1=res_addr2=res_addr4=5 -> wb_regld=1000. The same test on res_segld=0110 with equal segaddr -> wb_segld=0100.
- Fill/backpressure: wb_hold=1, push 4 bundles -> occupancy=4, res_ready=0. A 5th res_valid is not accepted. Release hold -> bundles emerge in order, one per cycle, and occupancy counts down 4..0.
- Wrap: 10 back-to-back pushes with hold toggling every other cycle -> output order matches input order, none lost or duplicated.
- Flush: occupancy=3, assert flush with res_valid=1 -> next cycle occupancy=0, wb_regld=0, wb_segld=0, and the pushed bundle never appears.
- Reset mid-operation: clr=1 with occupancy=2 and wb_regld=1111 -> all outputs 0, res_ready=1 after the edge.
